// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1-style serialiser; optional parity bit via UART_TX_PARITY_EN.
// Line falls one clk after a write into an idle empty FIFO; tx_ready drops while the FIFO is full.

module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_vld,
  output logic [W-1:0]     head_dat,
  output logic             full,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_vld, pop_vld})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (level == LVL_W'(DEPTH));
endmodule

module uart_tx_buffered #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_valid,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_ready,
  output logic [LVL_W-1:0]        fifo_level,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);
  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = 3;

  if (CPB < 2 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_buffered: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic                    txd_q, txd_d;
  logic                    rdy_en_q;
  logic                    bit_end;
  logic                    last_stop;
  logic                    launch;
  logic                    push;
  logic                    full;
  logic [PAYLOAD_BITS-1:0] head_dat;
`ifdef UART_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  uart_tx_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push),
    .push_dat (tx_data),
    .pop_vld  (launch),
    .head_dat (head_dat),
    .full     (full),
    .level    (fifo_level)
  );

  assign push      = tx_valid && tx_ready;
  assign bit_end   = (cyc_q == CNT_W'(CPB - 1));
  assign last_stop = (state_q == S_STOP) && bit_end && (idx_q == IDX_W'(STOP_BITS - 1));
  // A new frame starts either from idle or straight off the last stop bit, so queued words leave no gap.
  assign launch    = ((state_q == S_IDLE) || last_stop) && (fifo_level != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    cyc_d   = (state_q == S_IDLE || bit_end) ? '0 : cyc_q + CNT_W'(1);
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: txd_d = 1'b1;
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (last_stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (bit_end) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (launch) begin
      state_d = S_START;
      idx_d   = '0;
      txd_d   = 1'b0;
      shreg_d = head_dat;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head_dat) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
      rdy_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      txd_q    <= txd_d;
      rdy_en_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx_ready     = rdy_en_q && !full;
  assign uart_tx_busy = (state_q != S_IDLE) || (fifo_level != '0);
  assign uart_txd     = txd_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 10 clk per bit: frame shapes, FIFO backpressure, reset abort.
// Main instance 8 data / 1 stop; second instance 5 data / 2 stops.

module tb_uart_tx_buffered;
  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [2:0] fifo_level;
  logic       uart_tx_busy;
  logic       uart_txd;

  logic       tx_valid2;
  logic [4:0] tx_data2;
  logic       tx_ready2;
  logic [2:0] fifo_level2;
  logic       busy2;
  logic       txd2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // transmission order, bit 0 = start bit
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  uart_tx_buffered #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8),
                     .STOP_BITS(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .uart_tx_busy(uart_tx_busy), .uart_txd(uart_txd));

  uart_tx_buffered #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(5),
                     .STOP_BITS(2), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready2),
    .fifo_level(fifo_level2), .uart_tx_busy(busy2), .uart_txd(txd2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] line_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (fifo_level > 3'd4 || fifo_level2 > 3'd4) begin
        errors++;
        $display("FAIL level_bound: got %0d/%0d expected <=4", fifo_level, fifo_level2);
      end
    end
  end

  // Caller must be just past the edge where the line is expected to fall.
  task automatic check_frame(input string name, input logic [7:0] d, input logic [9:0] line);
    logic b [12];
    int   n;
    logic seen;
    logic bsy;
    for (int i = 0; i < 9; i++) b[i] = line[i];
`ifdef UART_TX_PARITY_EN
    b[9]  = ^d;
    b[10] = 1'b1;
    n     = 11;
`else
    b[9]  = line[9];
    n     = 10;
`endif
    bsy = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      seen = uart_txd;
      if (!uart_tx_busy) bsy = 1'b0;
      for (int c = 1; c < 10; c++) begin
        @(negedge clk);
        if (uart_txd !== b[k]) seen = uart_txd;
        if (!uart_tx_busy) bsy = 1'b0;
      end
      chk($sformatf("%s_d%0h_bit%0d", name, d, k), 32'(seen), 32'(b[k]));
    end
    chk($sformatf("%s_d%0h_busy", name, d), 32'(bsy), 32'd1);
  endtask

  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_busy"}, 32'(uart_tx_busy), 32'd0);
    chk({name, "_txd"}, 32'(uart_txd), 32'd1);
    chk({name, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic sbusy;
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    vecs[0] = '{data: 8'hA5, line: 10'b1_10100101_0};
    vecs[1] = '{data: 8'h00, line: 10'b1_00000000_0};
    vecs[2] = '{data: 8'hFF, line: 10'b1_11111111_0};
    vecs[3] = '{data: 8'h3C, line: 10'b1_00111100_0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy", 32'(uart_tx_busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1 chk("ready_after_edge", 32'(tx_ready), 32'd1);

    // Single frames from idle.
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].data);
      chk("not_early", 32'(uart_txd), 32'd1);
      @(posedge clk);
      check_frame("single", vecs[i].data, vecs[i].line);
      check_idle("single_end");
    end

    // Five back-to-back words into depth 4, plus a word offered while full.
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          tx_valid = 1'b1;
          tx_data  = 8'(i);
          @(posedge clk);
          #1;
        end
        tx_data = 8'hEE;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("full_ready", 32'(tx_ready), 32'd0);
          chk("full_level", 32'(fifo_level), 32'd4);
          @(posedge clk);
          #1;
        end
        tx_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        for (int i = 1; i <= 5; i++) check_frame("burst", 8'(i), line_of(8'(i)));
      end
    join
    check_idle("burst_end");

    // Push coinciding with the end-of-frame pop while two words are queued.
    fork
      begin
        push(8'h5A);
        push(8'hC3);
        push(8'h81);
        repeat (98) @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        @(negedge clk);
        chk("pp_level_before", 32'(fifo_level), 32'd2);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        chk("pp_level_after", 32'(fifo_level), 32'd2);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        check_frame("pp", 8'h5A, line_of(8'h5A));
        check_frame("pp", 8'hC3, line_of(8'hC3));
        check_frame("pp", 8'h81, line_of(8'h81));
        check_frame("pp", 8'h96, line_of(8'h96));
      end
    join
    check_idle("pp_end");

    // Reset at cycle 35 of a frame with three words queued.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("abort_level", 32'(fifo_level), 32'd3);
    repeat (33) @(posedge clk);
    #1 chk("abort_midframe_txd", 32'(uart_txd), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("abort_txd", 32'(uart_txd), 32'd1);
    chk("abort_lvl", 32'(fifo_level), 32'd0);
    chk("abort_ready", 32'(tx_ready), 32'd0);
    chk("abort_busy", 32'(uart_tx_busy), 32'd0);
    @(negedge clk);
    chk("abort_ready_held", 32'(tx_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b1;
    sbusy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) seen = uart_txd;
      if (uart_tx_busy !== 1'b0) sbusy = uart_tx_busy;
    end
    chk("post_abort_txd", 32'(seen), 32'd1);
    chk("post_abort_busy", 32'(sbusy), 32'd0);
    chk("post_abort_ready", 32'(tx_ready), 32'd1);

    // 5 data bits, 2 stop bits: start, five ones, then stop high.
    tx_valid2 = 1'b1;
    tx_data2  = 5'h1F;
    @(posedge clk);
    #1 tx_valid2 = 1'b0;
    chk("s2_not_early", 32'(txd2), 32'd1);
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (txd2 !== 1'b0) seen = txd2;
    end
    chk("s2_start", 32'(seen), 32'd0);
    seen = 1'b1;
    sbusy = 1'b1;
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < 80; c++) begin
`else
    for (int c = 0; c < 70; c++) begin
`endif
      @(negedge clk);
      if (txd2 !== 1'b1) seen = txd2;
      if (busy2 !== 1'b1) sbusy = busy2;
    end
    chk("s2_high", 32'(seen), 32'd1);
    chk("s2_busy", 32'(sbusy), 32'd1);
    @(negedge clk);
    chk("s2_done_busy", 32'(busy2), 32'd0);
    chk("s2_done_txd", 32'(txd2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
